// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared geometry, colour constants and lane helpers for the note scroller
package note_pkg;

    localparam int ROWS   = 7;
    localparam int COLS   = 64;
    localparam int LANES  = 4;
    localparam int PIX_W  = 3;
    localparam int LANE_W = COLS / LANES;

    localparam logic [PIX_W-1:0] RED   = 3'b100;
    localparam logic [PIX_W-1:0] GREEN = 3'b010;
    localparam logic [PIX_W-1:0] BLUE  = 3'b001;
    localparam logic [PIX_W-1:0] WHITE = 3'b111;
    localparam logic [PIX_W-1:0] OFF   = 3'b000;

    // Bit offset of a lane's first pixel inside a packed row.
    function automatic int seg_lsb(input int lane, input int lane_w);
        return lane * lane_w * PIX_W;
    endfunction

endpackage

// File: rtl/note_scroll_scheduler_rr_arbiter.sv
// rtl/note_scroll_scheduler_rr_arbiter.sv - round-robin one-hot arbiter with hold
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Search starts at the pointer; the winner's successor becomes the next pointer.
    always_comb begin : search
        logic found;
        int   idx;
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (!hold) begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d      = PW'((idx + 1) % N);
                end
            end
        end
    end

endmodule

// File: rtl/note_scroll_scheduler.sv
// rtl/note_scroll_scheduler.sv - owns the seven note rows: frame-aligned scroll, spawns, hits, misses
module note_scroll_scheduler #(
    parameter int ROWS     = 7,
    parameter int COLS     = 64,
    parameter int LANES    = 4,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 frame_done,
    input  logic [LANES-1:0]     spawn_req,
    input  logic [3*LANES-1:0]   spawn_color,
    output logic [LANES-1:0]     spawn_ack,
    input  logic [LANES-1:0]     hit_req,
    output logic [LANES-1:0]     hit_ok,
    output logic [LANES-1:0]     hit_bad,
    output logic [LANES-1:0]     miss,
    output logic [3*COLS-1:0]    notesMap0,
    output logic [3*COLS-1:0]    notesMap1,
    output logic [3*COLS-1:0]    notesMap2,
    output logic [3*COLS-1:0]    notesMap3,
    output logic [3*COLS-1:0]    notesMap4,
    output logic [3*COLS-1:0]    notesMap5,
    output logic [3*COLS-1:0]    notesMap6
);

    import note_pkg::*;

    localparam int LW    = COLS / LANES;
    localparam int SEG_W = LW * PIX_W;
    localparam int ROW_W = COLS * PIX_W;
    localparam int TW    = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]    tick_q, tick_d;
    logic             pending_q, pending_d;
    logic [ROW_W-1:0] map_q [ROWS];
    logic [ROW_W-1:0] map_d [ROWS];
    logic [LANES-1:0] ack_q, ack_d;
    logic [LANES-1:0] hit_ok_q, hit_ok_d;
    logic [LANES-1:0] hit_bad_q, hit_bad_d;
    logic [LANES-1:0] miss_q, miss_d;

    logic             wrap;
    logic             shift;
    logic [LANES-1:0] grant;

    // A wrap while a shift is already pending is simply absorbed by the set.
    always_comb begin
        wrap      = run && (tick_q == TICK_LAST);
        shift     = pending_q && frame_done;
        tick_d    = tick_q;
        if (run) begin
            tick_d = wrap ? '0 : tick_q + TW'(1);
        end
        pending_d = pending_q;
        if (shift) begin
            pending_d = 1'b0;
        end
        if (wrap) begin
            pending_d = 1'b1;
        end
    end

    rr_arbiter #(
        .N(LANES)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (spawn_req),
        .hold (shift),
        .grant(grant)
    );

    // Hits look at the pre-update bottom row; a shift then overwrites row 6 wholesale.
    always_comb begin
        map_d     = map_q;
        hit_ok_d  = '0;
        hit_bad_d = '0;
        miss_d    = '0;
        ack_d     = grant;
        for (int l = 0; l < LANES; l++) begin
            if (hit_req[l]) begin
                if (|map_q[ROWS-1][seg_lsb(l, LW) +: SEG_W]) begin
                    hit_ok_d[l] = 1'b1;
                    map_d[ROWS-1][seg_lsb(l, LW) +: SEG_W] = '0;
                end else begin
                    hit_bad_d[l] = 1'b1;
                end
            end else if (shift && (|map_q[ROWS-1][seg_lsb(l, LW) +: SEG_W])) begin
                miss_d[l] = 1'b1;
            end
        end
        if (shift) begin
            for (int r = ROWS - 1; r > 0; r--) begin
                map_d[r] = map_q[r-1];
            end
            map_d[0] = '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (grant[l]) begin
                    map_d[0][seg_lsb(l, LW) +: SEG_W] = {LW{spawn_color[3*l +: 3]}};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= '0;
            hit_ok_q  <= '0;
            hit_bad_q <= '0;
            miss_q    <= '0;
            for (int r = 0; r < ROWS; r++) begin
                map_q[r] <= '0;
            end
        end else begin
            tick_q    <= tick_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            hit_ok_q  <= hit_ok_d;
            hit_bad_q <= hit_bad_d;
            miss_q    <= miss_d;
            for (int r = 0; r < ROWS; r++) begin
                map_q[r] <= map_d[r];
            end
        end
    end

    assign spawn_ack = ack_q;
    assign hit_ok    = hit_ok_q;
    assign hit_bad   = hit_bad_q;
    assign miss      = miss_q;
    assign notesMap0 = map_q[0];
    assign notesMap1 = map_q[1];
    assign notesMap2 = map_q[2];
    assign notesMap3 = map_q[3];
    assign notesMap4 = map_q[4];
    assign notesMap5 = map_q[5];
    assign notesMap6 = map_q[6];

endmodule

// File: tb/tb_note_scroll_scheduler.sv
// tb/tb_note_scroll_scheduler.sv - directed self-checking bench for note_scroll_scheduler
module tb_note_scroll_scheduler;

    localparam int ROW_W = 192;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              frame_done = 1'b0;
    logic [3:0]        spawn_req = '0;
    logic [11:0]       spawn_color = '0;
    logic [3:0]        spawn_ack;
    logic [3:0]        hit_req = '0;
    logic [3:0]        hit_ok;
    logic [3:0]        hit_bad;
    logic [3:0]        miss;
    logic [ROW_W-1:0]  nm [7];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    note_scroll_scheduler #(
        .ROWS(7), .COLS(64), .LANES(4), .TICK_DIV(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .frame_done (frame_done),
        .spawn_req  (spawn_req),
        .spawn_color(spawn_color),
        .spawn_ack  (spawn_ack),
        .hit_req    (hit_req),
        .hit_ok     (hit_ok),
        .hit_bad    (hit_bad),
        .miss       (miss),
        .notesMap0  (nm[0]),
        .notesMap1  (nm[1]),
        .notesMap2  (nm[2]),
        .notesMap3  (nm[3]),
        .notesMap4  (nm[4]),
        .notesMap5  (nm[5]),
        .notesMap6  (nm[6])
    );

    function automatic logic [ROW_W-1:0] seg(input int lane, input logic [2:0] col);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int c = lane * 16; c < lane * 16 + 16; c++) begin
            r[3*c +: 3] = col;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        frame_done = 1'b0;
        spawn_req = '0;
        spawn_color = '0;
        hit_req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic spawn_setup(input int lane, input logic [2:0] col);
        spawn_color[3*lane +: 3] = col;
        spawn_req = 4'(1 << lane);
        tick();
        spawn_req = '0;
    endtask

    // Four running cycles guarantee exactly one wrap; the shift then lands on the frame pulse.
    task automatic shift_once(input logic [3:0] hit, input logic [3:0] sreq);
        run = 1'b1;
        repeat (4) tick();
        run = 1'b0;
        frame_done = 1'b1;
        hit_req = hit;
        spawn_req = sreq;
        tick();
        frame_done = 1'b0;
        hit_req = '0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int r = 0; r < 7; r++) begin
            n_cmp++;
            if (nm[r] !== '0) begin
                n_bad++;
                $display("FAIL reset_map%0d got %h want 0", r, nm[r]);
            end
        end
        n_cmp++;
        if ({spawn_ack, hit_ok, hit_bad, miss} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", {spawn_ack, hit_ok, hit_bad, miss});
        end
    endtask

    task automatic test_spawn();
        spawn_color[2:0] = 3'b100;
        spawn_req = 4'b0001;
        tick();
        spawn_req = '0;
        n_cmp++;
        if (spawn_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL spawn_ack got %b want 0001", spawn_ack);
        end
        n_cmp++;
        if (nm[0] !== {144'h0, {16{3'b100}}}) begin
            n_bad++;
            $display("FAIL spawn_map0 got %h want %h", nm[0], {144'h0, {16{3'b100}}});
        end
        n_cmp++;
        if (nm[1] !== '0) begin
            n_bad++;
            $display("FAIL spawn_map1 got %h want 0", nm[1]);
        end
        tick();
        n_cmp++;
        if (spawn_ack !== 4'b0000) begin
            n_bad++;
            $display("FAIL spawn_ack_pulse got %b want 0000", spawn_ack);
        end
    endtask

    task automatic test_contention();
        logic [3:0] want;
        do_reset();
        spawn_color = {3'b111, 3'b001, 3'b010, 3'b100};
        spawn_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            want = 4'(1 << i);
            n_cmp++;
            if (spawn_ack !== want) begin
                n_bad++;
                $display("FAIL contention_ack%0d got %b want %b", i, spawn_ack, want);
            end
            spawn_req[i] = 1'b0;
        end
        n_cmp++;
        if (nm[0] !== (seg(0, 3'b100) | seg(1, 3'b010) | seg(2, 3'b001) | seg(3, 3'b111))) begin
            n_bad++;
            $display("FAIL contention_map0 got %h", nm[0]);
        end
    endtask

    task automatic test_deferred_shift();
        do_reset();
        spawn_setup(0, 3'b100);
        run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            frame_done = (k == 1);
            tick();
            n_cmp++;
            if (nm[1] !== '0) begin
                n_bad++;
                $display("FAIL deferred_early_shift k=%0d got %h want 0", k, nm[1]);
            end
        end
        frame_done = 1'b1;
        tick();
        n_cmp++;
        if (nm[1] !== seg(0, 3'b100)) begin
            n_bad++;
            $display("FAIL deferred_shift_map1 got %h want %h", nm[1], seg(0, 3'b100));
        end
        n_cmp++;
        if (nm[0] !== '0) begin
            n_bad++;
            $display("FAIL deferred_shift_map0 got %h want 0", nm[0]);
        end
        tick();
        n_cmp++;
        if (nm[2] !== '0 || nm[1] !== seg(0, 3'b100)) begin
            n_bad++;
            $display("FAIL deferred_single_shift map2 %h map1 %h want 0 / %h", nm[2], nm[1], seg(0, 3'b100));
        end
        frame_done = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_scroll_off();
        do_reset();
        spawn_setup(2, 3'b010);
        repeat (6) shift_once(4'b0000, 4'b0000);
        n_cmp++;
        if (nm[6] !== seg(2, 3'b010) || nm[5] !== '0) begin
            n_bad++;
            $display("FAIL scroll_to_map6 got %h / %h want %h / 0", nm[6], nm[5], seg(2, 3'b010));
        end
        n_cmp++;
        if (miss !== 4'b0000) begin
            n_bad++;
            $display("FAIL scroll_no_early_miss got %b want 0000", miss);
        end
        shift_once(4'b0000, 4'b0000);
        n_cmp++;
        if (miss !== 4'b0100) begin
            n_bad++;
            $display("FAIL scroll_miss got %b want 0100", miss);
        end
        n_cmp++;
        if (nm[6] !== '0) begin
            n_bad++;
            $display("FAIL scroll_off_map6 got %h want 0", nm[6]);
        end
        tick();
        n_cmp++;
        if (miss !== 4'b0000) begin
            n_bad++;
            $display("FAIL scroll_miss_pulse got %b want 0000", miss);
        end
    endtask

    task automatic test_hit();
        do_reset();
        spawn_setup(1, 3'b001);
        repeat (6) shift_once(4'b0000, 4'b0000);
        hit_req = 4'b0010;
        tick();
        hit_req = '0;
        n_cmp++;
        if (hit_ok !== 4'b0010 || hit_bad !== 4'b0000) begin
            n_bad++;
            $display("FAIL hit_ok got ok=%b bad=%b want ok=0010 bad=0000", hit_ok, hit_bad);
        end
        n_cmp++;
        if (nm[6] !== '0) begin
            n_bad++;
            $display("FAIL hit_clear got %h want 0", nm[6]);
        end
        hit_req = 4'b0010;
        tick();
        hit_req = '0;
        n_cmp++;
        if (hit_bad !== 4'b0010 || hit_ok !== 4'b0000) begin
            n_bad++;
            $display("FAIL hit_bad got ok=%b bad=%b want ok=0000 bad=0010", hit_ok, hit_bad);
        end
        tick();
        n_cmp++;
        if (hit_bad !== 4'b0000) begin
            n_bad++;
            $display("FAIL hit_bad_pulse got %b want 0000", hit_bad);
        end
    endtask

    task automatic test_hit_on_shift();
        do_reset();
        spawn_setup(3, 3'b111);
        repeat (6) shift_once(4'b0000, 4'b0000);
        spawn_color[2:0] = 3'b100;
        shift_once(4'b1000, 4'b0001);
        n_cmp++;
        if (hit_ok !== 4'b1000 || miss !== 4'b0000) begin
            n_bad++;
            $display("FAIL shift_hit got ok=%b miss=%b want ok=1000 miss=0000", hit_ok, miss);
        end
        n_cmp++;
        if (spawn_ack !== 4'b0000 || nm[0] !== '0 || nm[6] !== '0) begin
            n_bad++;
            $display("FAIL shift_blocks_spawn ack=%b map0=%h map6=%h want 0", spawn_ack, nm[0], nm[6]);
        end
        tick();
        spawn_req = '0;
        n_cmp++;
        if (spawn_ack !== 4'b0001 || nm[0] !== seg(0, 3'b100)) begin
            n_bad++;
            $display("FAIL shift_then_spawn ack=%b map0=%h want 0001 / %h", spawn_ack, nm[0], seg(0, 3'b100));
        end
    endtask

    task automatic test_reset_midrun();
        run = 1'b1;
        repeat (4) tick();
        run = 1'b0;
        spawn_setup(2, 3'b001);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (spawn_ack !== 4'b0000 || nm[0] !== '0) begin
            n_bad++;
            $display("FAIL async_reset ack=%b map0=%h want 0", spawn_ack, nm[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        spawn_setup(0, 3'b100);
        run = 1'b1;
        frame_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (nm[1] !== '0) begin
                n_bad++;
                $display("FAIL reset_clears_pending k=%0d got %h want 0", k, nm[1]);
            end
        end
        tick();
        n_cmp++;
        if (nm[1] !== seg(0, 3'b100)) begin
            n_bad++;
            $display("FAIL reset_first_shift got %h want %h", nm[1], seg(0, 3'b100));
        end
        frame_done = 1'b0;
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_contention();
        test_deferred_shift();
        test_scroll_off();
        test_hit();
        test_hit_on_shift();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/note_scroll_scheduler.md
# note_scroll_scheduler

Owns the seven 64-pixel note rows shown on the LED matrix and sequences every change to them: periodic downward scrolling, note spawns from several lane requesters, and player hit checks against the bottom row. Drives the `notesMap0..6` inputs of the matrix scan driver. Scrolling is deferred to frame boundaries so the scan never latches a half-updated image.

## Interface
- `ROWS`, 7, number of note rows (fixed by the driver).
- `COLS`, 64, pixels per row.
- `LANES`, 4, lanes; lane `l` owns columns `l*COLS/LANES` to `(l+1)*COLS/LANES-1` (16 wide at defaults).
- `TICK_DIV`, 25_000_000, `clk` cycles per scroll step; must be at least 2.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `run`, in, 1, scroll enable; 0 freezes the tick counter.
- `frame_done`, in, 1, one-cycle pulse from the scan driver at the end of a full frame.
- `spawn_req`, in, LANES, level per lane; held until acked.
- `spawn_color`, in, 3*LANES, `{R,G,B}` for lane `l` at `[3l+2:3l]`; stable while req is high.
- `spawn_ack`, out, LANES, one-cycle grant pulse.
- `hit_req`, in, LANES, one-cycle player press per lane.
- `hit_ok`, out, LANES, one-cycle pulse: press matched a note.
- `hit_bad`, out, LANES, one-cycle pulse: press on an empty lane.
- `miss`, out, LANES, one-cycle pulse: note scrolled off unhit.
- `notesMap0`..`notesMap6`, out, 3*COLS each; pixel `c` at `[3c+2:3c]` = `{R,G,B}`. Map0 is the top (spawn) row, map6 the bottom (hit) row.

## Operation
- Tick counter counts 0 to TICK_DIV-1 while `run`=1. On wrap it sets `shift_pending`. A second wrap while a shift is still pending is dropped (no queueing).
- Shift happens in the cycle where `shift_pending` and `frame_done` are both 1:
  - map6 gets map5, and so on down to map1 getting map0.
  - map0 clears to 0.
  - `shift_pending` clears.
- Miss: on a shift, each lane whose pre-shift map6 segment is nonzero and has no `hit_req` that cycle pulses `miss[l]`.
- Hit, evaluated every cycle for every lane with `hit_req[l]`:
  - If the pre-update map6 segment is nonzero: clear the segment and pulse `hit_ok[l]`. On a shift cycle this also suppresses that lane's `miss`.
  - Otherwise pulse `hit_bad[l]`.
- Spawn:
  - A round-robin arbiter grants at most one pending `spawn_req` per cycle.
  - The granted lane's map0 segment gets `spawn_color` on all its columns, and `spawn_ack` pulses for that lane.
  - Pointer advances to grant+1 (mod LANES) after each grant.
- Priority: on a shift cycle no spawn is granted; requests stay pending. Hits on a shift cycle use the pre-shift map6.
- Spawn onto an occupied map0 segment overwrites it.
- `run`=0 does not block hits, spawns, or an already-pending shift.
- Reset, including mid-operation:
  - all maps 0; all outputs 0;
  - tick counter 0, `shift_pending` 0, arbiter pointer 0.

## Timing
- All outputs are registered.
- Map updates are visible the cycle after the triggering edge.
- `spawn_ack`, `hit_ok`, `hit_bad`, and `miss` pulse exactly one cycle, aligned with that map update.
- Spawn latency: 1 cycle from req to ack with no contention. Worst case is LANES cycles, or LANES+1 if a shift intervenes.
- Requester deasserts `spawn_req[l]` the cycle after its ack. If still high, it is treated as a new request.
- The first shift happens at the first `frame_done` at or after cycle TICK_DIV following reset release with `run`=1.

## Structure
- Shared package `note_pkg` holds:
  - ROWS, COLS, LANES, PIX_W=3, LANE_W=COLS/LANES;
  - color constants RED=3'b100, GREEN=3'b010, BLUE=3'b001, WHITE=3'b111, OFF=3'b000;
  - a lane-segment index function.
- Sub-module `rr_arbiter`, parameterized N: req in, one-hot grant out, pointer update on grant, hold input (asserted on shift cycles).
- Top contains the tick counter, pending flag, row registers, and hit/miss logic.

## Test plan
- Spawn: after reset, `spawn_req`=4'b0001 with color 3'b100 → `spawn_ack`=0001 next cycle; map0[47:0] = 16 × 3'b100, rest 0.
- Contention: `spawn_req`=4'b1111 held, each lane deasserted after its ack → acks 0001, 0010, 0100, 1000 on consecutive cycles.
- Deferred shift, TICK_DIV=4, `run`=1, `frame_done` first at cycle 10 → no shift before cycle 10. At 10 map0 moves to map1. Two wraps before `frame_done` give one shift only.
- Scroll-off: note in lane 2 scrolled to map6; next shift with no hit → `miss`=0100 and map6 lane 2 cleared.
- Hit:
  - map6 lane 1 nonzero with `hit_req`=0010 → `hit_ok`=0010 and segment zero; repeat press → `hit_bad`=0010.
  - Press coinciding with a shift → `hit_ok`, no `miss`.
- Reset mid-run: assert `rst` with maps populated and a shift pending → outputs 0 asynchronously; after release, no shift until TICK_DIV cycles elapse.
